// File: rtl/dsc_pkg.sv
// Shared types and helpers for the DSC stream blocks.
// Holds the popcount used on multi-bit stream slices and the legal STRIDE set.
package dsc_pkg;

    localparam int unsigned MAX_STRIDE = 4;
    localparam int unsigned PC_W       = 3;

    typedef enum logic {
        S2B_SYNC  = 1'b0,
        S2B_ACCUM = 1'b1
    } s2b_state_t;

    // Upstream SNGs only ever emit 1, 2 or 4 bits per cycle.
    function automatic bit stride_legal(input int unsigned s);
        return (s == 1) || (s == 2) || (s == 4);
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_STRIDE-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < MAX_STRIDE; i++) begin
            cnt = cnt + PC_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dsc_out_reg.sv
// Single-entry valid/ready holding register.
// A word offered while the entry is full and not being drained is dropped and flagged.
module dsc_out_reg #(
    parameter int unsigned DW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_offer,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_drop
);

    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_drop;
    logic          w_load;

    // Load when empty or when the current word is consumed in the same cycle.
    assign w_load = i_offer && (!r_valid || i_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_offer && !w_load) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_drop  = r_drop;

endmodule

// File: rtl/dsc_s2b.sv
// Stochastic-to-binary converter: counts stream 1s over one SNG period
// (delimited by the upstream overflow pulse) and emits the count via valid/ready.
module dsc_s2b
    import dsc_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned STRIDE       = 1,
    parameter bit          START_SYNCED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [STRIDE-1:0] sn_in,
    input  logic              period_end,
    output logic [WIDTH:0]    bin_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop_err
);

    localparam int unsigned ACC_W = WIDTH + 1;
    localparam s2b_state_t  RST_STATE = START_SYNCED ? S2B_ACCUM : S2B_SYNC;

    if (!stride_legal(STRIDE)) begin : g_stride_chk
        $error("dsc_s2b: STRIDE must be 1, 2 or 4");
    end

    s2b_state_t        r_state;
    s2b_state_t        w_state_nx;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_nx;
    logic [ACC_W-1:0]  w_result;
    logic [PC_W-1:0]   w_pc;
    logic              w_offer;

    assign w_pc = popcount(MAX_STRIDE'(sn_in));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_STATE;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
        end
    end

    // Everything holds while en is low; period_end closes a period only in ACCUM.
    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_offer    = 1'b0;
        w_result   = r_acc + ACC_W'(w_pc);
        if (en) begin
            case (r_state)
                S2B_SYNC: begin
                    if (period_end) begin
                        w_state_nx = S2B_ACCUM;
                        w_acc_nx   = '0;
                    end
                end
                S2B_ACCUM: begin
                    if (period_end) begin
                        w_offer  = 1'b1;
                        w_acc_nx = '0;
                    end else begin
                        w_acc_nx = w_result;
                    end
                end
                default: begin
                    w_state_nx = RST_STATE;
                    w_acc_nx   = '0;
                end
            endcase
        end
    end

    dsc_out_reg #(
        .DW (ACC_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst),
        .i_offer (w_offer),
        .i_data  (w_result),
        .i_ready (out_ready),
        .o_data  (bin_out),
        .o_valid (out_valid),
        .o_drop  (drop_err)
    );

endmodule
